alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 54 +++++
 rtl/alu_regfile.sv | 33 +++
 rtl/alu_issue.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue block: opcode codes, flag bit positions,
// FSM state encodings and opcode classification helpers.
package alu_issue_pkg;

  localparam int OPC_W = 5;
  localparam int IDX_W = 3;

  localparam logic [OPC_W-1:0] OP_NOT = 5'h00;
  localparam logic [OPC_W-1:0] OP_AND = 5'h01;
  localparam logic [OPC_W-1:0] OP_OR  = 5'h02;
  localparam logic [OPC_W-1:0] OP_NEG = 5'h03;
  localparam logic [OPC_W-1:0] OP_ADD = 5'h04;
  localparam logic [OPC_W-1:0] OP_SUB = 5'h05;
  localparam logic [OPC_W-1:0] OP_MUL = 5'h06;
  localparam logic [OPC_W-1:0] OP_LD  = 5'h07;
  localparam logic [OPC_W-1:0] OP_STR = 5'h08;
  localparam logic [OPC_W-1:0] OP_JZ  = 5'h09;
  localparam logic [OPC_W-1:0] OP_JMP = 5'h0A;

  localparam int FLAG_C = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [OPC_W-1:0] op);
    case (op)
      OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB,
      OP_MUL, OP_LD, OP_STR, OP_JZ, OP_JMP: is_legal = 1'b1;
      default:                              is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [OPC_W-1:0] op);
    case (op)
      OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB, OP_MUL, OP_LD: writes_rd = 1'b1;
      default:                                                      writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic updates_flags(input logic [OPC_W-1:0] op);
    case (op)
      OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB, OP_MUL: updates_flags = 1'b1;
      default:                                               updates_flags = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for alu_issue: two combinational read ports, one synchronous
// write port, R0 hard-wired to zero, synchronous active-high clear.
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int BITS_DATA = 32,
  parameter int NUM_REGS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_W-1:0]     ra,
  input  logic [IDX_W-1:0]     rb,
  output logic [BITS_DATA-1:0] rdata_a,
  output logic [BITS_DATA-1:0] rdata_b,
  input  logic                 we,
  input  logic [IDX_W-1:0]     wa,
  input  logic [BITS_DATA-1:0] wdata
);

  logic [BITS_DATA-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wdata;
    end
  end

  assign rdata_a = (ra == '0) ? '0 : regs[ra];
  assign rdata_b = (rb == '0) ? '0 : regs[rb];

endmodule

// File: rtl/alu_issue.sv
// Serial four-state issue controller feeding an external ALU and writing back
// to a local register file. Flags register present only with ALU_ISSUE_FLAGS_EN.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int BITS_DATA = 32,
  parameter int NUM_REGS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPC_W-1:0]     in_opcode,
  input  logic [IDX_W-1:0]     in_rd,
  input  logic [IDX_W-1:0]     in_ra,
  input  logic [IDX_W-1:0]     in_rb,
  input  logic                 in_sel_imm,
  input  logic [BITS_DATA-1:0] in_imm,
  output logic [BITS_DATA-1:0] alu_operando_a,
  output logic [BITS_DATA-1:0] alu_operando_b,
  output logic [OPC_W-1:0]     alu_opcode,
  input  logic [BITS_DATA-1:0] alu_resultado,
  input  logic                 alu_C,
  input  logic                 alu_S,
  input  logic                 alu_O,
  input  logic                 alu_Z,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [IDX_W-1:0]     wb_rd,
  output logic [BITS_DATA-1:0] wb_data,
  output logic [3:0]           flags,
  output logic                 err
);

  state_t state_q, state_d;
  logic   accept;

  logic [OPC_W-1:0]     op_q;
  logic [IDX_W-1:0]     rd_q, ra_q, rb_q;
  logic                 sel_imm_q;
  logic [BITS_DATA-1:0] imm_q;
  logic [BITS_DATA-1:0] res_q;
  logic [BITS_DATA-1:0] rdata_a, rdata_b;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Outputs are masked by reset so nothing leaks while reset is held.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    wb_valid = 1'b0;
    wb_we    = 1'b0;
    err      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) begin
          accept  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        state_d  = ST_IDLE;
        wb_valid = !reset;
        wb_we    = !reset && writes_rd(op_q);
        err      = !reset && !is_legal(op_q);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wb_rd   = wb_valid ? rd_q  : '0;
  assign wb_data = wb_valid ? res_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q           <= '0;
      rd_q           <= '0;
      ra_q           <= '0;
      rb_q           <= '0;
      sel_imm_q      <= 1'b0;
      imm_q          <= '0;
      res_q          <= '0;
      alu_operando_a <= '0;
      alu_operando_b <= '0;
      alu_opcode     <= '0;
    end else begin
      if (accept) begin
        op_q      <= in_opcode;
        rd_q      <= in_rd;
        ra_q      <= in_ra;
        rb_q      <= in_rb;
        sel_imm_q <= in_sel_imm;
        imm_q     <= in_imm;
      end
      if (state_q == ST_READ) begin
        alu_operando_a <= rdata_a;
        alu_operando_b <= sel_imm_q ? imm_q : rdata_b;
        alu_opcode     <= op_q;
      end
      if (state_q == ST_EXEC) res_q <= alu_resultado;
    end
  end

  alu_regfile #(
    .BITS_DATA (BITS_DATA),
    .NUM_REGS  (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra      (ra_q),
    .rb      (rb_q),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (wb_we),
    .wa      (rd_q),
    .wdata   (res_q)
  );

`ifdef ALU_ISSUE_FLAGS_EN
  logic [3:0] alu_flags_q;
  logic [3:0] flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_flags_q <= '0;
      flags_q     <= '0;
    end else begin
      if (state_q == ST_EXEC) begin
        alu_flags_q[FLAG_C] <= alu_C;
        alu_flags_q[FLAG_S] <= alu_S;
        alu_flags_q[FLAG_O] <= alu_O;
        alu_flags_q[FLAG_Z] <= alu_Z;
      end
      if (state_q == ST_WB && updates_flags(op_q)) flags_q <= alu_flags_q;
    end
  end

  assign flags = flags_q;
`else
  logic unused_alu_flags;
  assign unused_alu_flags = &{1'b0, alu_C, alu_S, alu_O, alu_Z};
  assign flags = 4'b0000;
`endif

endmodule
